// File: rtl/instruction_fetch.sv
// Fetch-stage controller: owns the PC, reads instruction memory over req/ack, feeds the IF/ID slot.
// Define IFETCH_SKID_EN to add a one-entry skid buffer so a stalled fetch is kept instead of refetched.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instOut,
  output logic        instValid,
  output logic [31:0] instPC
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drainAddr_q, drainAddr_d;
  logic [31:0] instOut_q, instOut_d;
  logic [31:0] instPC_q, instPC_d;
  logic        instValid_q, instValid_d;
  logic        slotFree;
  logic [31:0] redirectAligned;
`ifdef IFETCH_SKID_EN
  logic [31:0] skidData_q, skidData_d;
  logic [31:0] skidPC_q, skidPC_d;
`endif

  assign slotFree        = !instValid_q || !stall;
  assign redirectAligned = {redirectPC[31:2], 2'b00};

  assign imemReq   = (state_q == FETCH) || (state_q == DRAIN);
  assign imemAddr  = (state_q == DRAIN) ? drainAddr_q : pc_q;
  assign instOut   = instOut_q;
  assign instPC    = instPC_q;
  assign instValid = instValid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drainAddr_q <= RESET_PC;
      instOut_q   <= '0;
      instPC_q    <= '0;
      instValid_q <= 1'b0;
`ifdef IFETCH_SKID_EN
      skidData_q  <= '0;
      skidPC_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drainAddr_q <= drainAddr_d;
      instOut_q   <= instOut_d;
      instPC_q    <= instPC_d;
      instValid_q <= instValid_d;
`ifdef IFETCH_SKID_EN
      skidData_q  <= skidData_d;
      skidPC_q    <= skidPC_d;
`endif
    end
  end

  // The skid entry is only ever live in WAIT, so leaving WAIT or redirecting empties it implicitly.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drainAddr_d = drainAddr_q;
    instOut_d   = instOut_q;
    instPC_d    = instPC_q;
    instValid_d = instValid_q;
`ifdef IFETCH_SKID_EN
    skidData_d  = skidData_q;
    skidPC_d    = skidPC_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          instValid_d = 1'b0;
          pc_d        = redirectAligned;
        end
      end
      FETCH: begin
        if (redirect) begin
          instValid_d = 1'b0;
          pc_d        = redirectAligned;
          drainAddr_d = pc_q;
          state_d     = imemAck ? FETCH : DRAIN;
        end else if (imemAck) begin
          if (slotFree) begin
            instOut_d   = imemData;
            instPC_d    = pc_q;
            instValid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
          end else begin
`ifdef IFETCH_SKID_EN
            skidData_d = imemData;
            skidPC_d   = pc_q;
            pc_d       = pc_q + PC_STEP;
`endif
            state_d = WAIT;
          end
        end else if (!stall) begin
          instValid_d = 1'b0;
        end
      end
      WAIT: begin
        if (redirect) begin
          instValid_d = 1'b0;
          pc_d        = redirectAligned;
          state_d     = FETCH;
        end else if (!stall) begin
`ifdef IFETCH_SKID_EN
          instOut_d   = skidData_q;
          instPC_d    = skidPC_q;
          instValid_d = 1'b1;
`else
          instValid_d = 1'b0;
`endif
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // The abandoned request must still complete before a new address may be presented.
        if (redirect) begin
          pc_d = redirectAligned;
        end
        if (imemAck) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage controller producing the instruction stream into the IF/ID pipeline register. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched word with its PC and a valid flag. Honours decode-stage stalls and branch/jump redirects; the IF/ID register samples `instOut` on each rising `clock`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset
- `PC_STEP`, 4, PC increment per accepted instruction (byte address)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  decode stage cannot accept; hold current output
- `redirect`  in  1  flush and restart fetch at `redirectPC`
- `redirectPC`  in  32  new fetch address; bits [1:0] forced to 0
- `imemReq`  out  1  read request to instruction memory
- `imemAddr`  out  32  read address; stable while `imemReq`=1 until ack
- `imemAck`  in  1  read data valid this cycle (may be same cycle as req)
- `imemData`  in  32  read data, valid when `imemAck`=1
- `instOut`  out  32  fetched instruction
- `instValid`  out  1  `instOut` holds a live instruction
- `instPC`  out  32  address of `instOut`

## Operation
- Output slot {`instOut`,`instPC`,`instValid`}; slot "free" when `instValid`=0 or `stall`=0.
- States: IDLE, FETCH, WAIT, DRAIN. `imemReq`=1 only in FETCH and DRAIN. `imemAddr` = internal `pc` in FETCH, the outstanding address in DRAIN.
- IDLE: entered on reset; unconditionally -> FETCH next edge.
- FETCH, `imemAck`=1, slot free: load slot with `imemData`/`pc`, `instValid`<=1, `pc`<=`pc`+`PC_STEP`, stay FETCH.
- FETCH, `imemAck`=1, slot not free: -> WAIT (data handling per Configuration).
- FETCH, `imemAck`=0, slot free and `stall`=0: `instValid`<=0 (consumed, nothing new).
- WAIT: `imemReq`=0; when `stall`=0 -> FETCH (per Configuration).
- Redirect (highest priority, ignores `stall`): `instValid`<=0, skid cleared, `pc`<=`redirectPC` & ~3. From FETCH with no ack this cycle -> DRAIN (request still outstanding). From FETCH with ack this cycle, WAIT, or IDLE -> FETCH; acked data discarded.
- DRAIN: hold old `imemAddr`, `imemReq`=1; on `imemAck` discard data -> FETCH. Redirect in DRAIN updates `pc` only, stays DRAIN.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- Reset (any time, incl. mid-request): state IDLE, `pc`=`RESET_PC`, `imemReq`=0, `imemAddr`=`RESET_PC`, `instOut`=0, `instPC`=0, `instValid`=0, skid empty. Outstanding memory request is abandoned; memory must tolerate this.

## Timing
- Zero-wait memory (ack same cycle as req): first `instValid`=1 after 2nd rising edge following reset release; then one instruction per cycle while `stall`=0.
- N-cycle memory: instruction latency N+1 edges per fetch; no pipelining of requests (one outstanding max).
- Redirect at edge k: `instValid`=0 after edge k; first redirected instruction valid after edge k+1 (zero-wait, not DRAIN).
- `stall` sampled at clock edge only; slot contents unchanged on any stalled edge.

## Configuration
- `IFETCH_SKID_EN` defined: one-entry skid buffer. FETCH ack with slot not free stores data and `pc` into skid, `pc` advances, -> WAIT. WAIT with `stall`=0 moves skid to slot same edge, -> FETCH. No refetch.
- Undefined: no skid. FETCH ack with slot not free discards data, `pc` unchanged, -> WAIT. WAIT with `stall`=0 -> FETCH, reissuing same `pc` (one extra memory access per such stall).

## Test plan
- Reset release, zero-wait memory returning addr as data: `instPC`/`instOut` = 0,4,8,12 on consecutive edges, first valid 2 edges after release.
- `stall`=1 for 3 cycles with `instPC`=8: slot holds 8 throughout; after release next `instPC`=12, none skipped or duplicated (both configs; without `IFETCH_SKID_EN` address 12 requested twice).
- Redirect to 32'h0000_0103 while `instPC`=20: `instValid`=0 next edge, then `instPC`=32'h100, 32'h104.
- 3-cycle ack latency, redirect to 32'h200 on cycle 1 of request: old `imemAddr` held until ack, data discarded, next `imemAddr`=32'h200.
- `RESET_PC`=32'hFFFF_FFF8: `instPC` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` while `imemReq`=1 and slot valid: `imemReq`, `instValid`, `instOut` = 0 immediately (asynchronously), fetch resumes at `RESET_PC`.
